// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//   Initiator-side controller for a 3-port register file (two combinational
//   reads, one write on posedge). Requests arrive over a valid/ready channel,
//   are sequenced onto the RF address/data/enable pins, and read data comes
//   back over a valid/ready response channel.
//
//   Handshake rule (both channels): a transfer happens on a rising clk edge
//   where valid and ready are both 1. The producer holds valid and its payload
//   stable until that edge, and ready never depends on valid.
//
//   Ports
//     clk, rst_n             clock; synchronous active-low reset
//     req_valid/req_ready    request channel (req_ready gated by rst_n)
//     req_write              1 = write request, 0 = read request
//     req_ra1/req_ra2        read addresses
//     req_wa/req_wd          write address / data
//     rsp_valid/rsp_ready    read response channel
//     rsp_rd1/rsp_rd2        captured read data for req_ra1 / req_ra2
//     rf_ra1/rf_ra2          to RF read ports
//     rf_wa3/rf_wd3/rf_we3   to RF write port
//     rf_rd1/rf_rd2          from RF read ports (combinational)
//     wr_count/rd_count      completed writes / read handshakes, wrapping
//     dbg_state              FSM state: 0 IDLE, 1 WRITE, 2 READ, 3 RESP
//
//   Timing: a write accepted at edge N pulses rf_we3 for the cycle after N,
//   so the RF is written at N+1. A read accepted at edge N drives rf_ra* for
//   the cycle after N, captures rf_rd* at N+1 and presents the response from
//   then on; with rsp_ready high a read occupies three cycles.
module regfile_access_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_ra1,
  input  logic [ADDR_W-1:0] req_ra2,
  input  logic [ADDR_W-1:0] req_wa,
  input  logic [DATA_W-1:0] req_wd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rd1,
  output logic [DATA_W-1:0] rsp_rd2,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  output logic [ADDR_W-1:0] rf_wa3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              rf_we3,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rf_ra1_q, rf_ra1_d;
  logic [ADDR_W-1:0] rf_ra2_q, rf_ra2_d;
  logic [ADDR_W-1:0] rf_wa3_q, rf_wa3_d;
  logic [DATA_W-1:0] rf_wd3_q, rf_wd3_d;
  logic              rf_we3_q, rf_we3_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rd1_q, rsp_rd1_d;
  logic [DATA_W-1:0] rsp_rd2_q, rsp_rd2_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;

  logic accept;
  logic zero_wr;
  logic zero_rd1;
  logic zero_rd2;

  assign req_ready = (state_q == S_IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  // Register 0 handling: writes are dropped at the enable, reads are masked
  // at capture so whatever the RF holds in entry 0 never leaks out.
  assign zero_wr  = (ZERO_REG != 0) && (req_wa == '0);
  assign zero_rd1 = (ZERO_REG != 0) && (rf_ra1_q == '0);
  assign zero_rd2 = (ZERO_REG != 0) && (rf_ra2_q == '0);

  always_comb begin
    state_d     = state_q;
    rf_ra1_d    = rf_ra1_q;
    rf_ra2_d    = rf_ra2_q;
    rf_wa3_d    = rf_wa3_q;
    rf_wd3_d    = rf_wd3_q;
    rf_we3_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rd1_d   = rsp_rd1_q;
    rsp_rd2_d   = rsp_rd2_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_write) begin
            rf_wa3_d = req_wa;
            rf_wd3_d = req_wd;
            rf_we3_d = !zero_wr;
            state_d  = S_WRITE;
          end else begin
            rf_ra1_d = req_ra1;
            rf_ra2_d = req_ra2;
            state_d  = S_READ;
          end
        end
      end
      S_WRITE: begin
        // A suppressed r0 write still counts as a completed write.
        wr_count_d = wr_count_q + CNT_W'(1);
        state_d    = S_IDLE;
      end
      S_READ: begin
        rsp_rd1_d   = zero_rd1 ? '0 : rf_rd1;
        rsp_rd2_d   = zero_rd2 ? '0 : rf_rd2;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rd_count_d  = rd_count_q + CNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rf_ra1_q    <= '0;
      rf_ra2_q    <= '0;
      rf_wa3_q    <= '0;
      rf_wd3_q    <= '0;
      rf_we3_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rd1_q   <= '0;
      rsp_rd2_q   <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rf_ra1_q    <= rf_ra1_d;
      rf_ra2_q    <= rf_ra2_d;
      rf_wa3_q    <= rf_wa3_d;
      rf_wd3_q    <= rf_wd3_d;
      rf_we3_q    <= rf_we3_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rd1_q   <= rsp_rd1_d;
      rsp_rd2_q   <= rsp_rd2_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
    end
  end

  assign rf_ra1    = rf_ra1_q;
  assign rf_ra2    = rf_ra2_q;
  assign rf_wa3    = rf_wa3_q;
  assign rf_wd3    = rf_wd3_q;
  assign rf_we3    = rf_we3_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rd1   = rsp_rd1_q;
  assign rsp_rd2   = rsp_rd2_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;
  assign dbg_state = state_q;

endmodule
